// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt controller.
package irq_pkg;

  // Per-channel trigger mode, one bit per channel in EDGE_MASK.
  localparam logic IRQ_MODE_LEVEL = 1'b0;
  localparam logic IRQ_MODE_EDGE  = 1'b1;

  // Default handler vector layout.
  localparam logic [31:0] IRQ_VEC_BASE   = 32'h0000_0400;
  localparam logic [31:0] IRQ_VEC_STRIDE = 32'h0000_0010;

  // Channel-ID width; a single channel still needs one bit.
  function automatic int unsigned irq_id_width(int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous interrupt line, plus a
// rising-edge pulse derived from one extra history flop.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw input through the synchroniser and keep the last level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// N-channel interrupt controller: synchronised edge/level inputs, masking,
// fixed priority with nesting, an in-service set, and a registered
// request/ack/return handshake towards the CPU.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned      N_IRQ       = 3,
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0] EDGE_MASK   = '1,
  parameter logic [WIDTH-1:0] VEC_BASE    = WIDTH'(IRQ_VEC_BASE),
  parameter logic [WIDTH-1:0] VEC_STRIDE  = WIDTH'(IRQ_VEC_STRIDE),
  localparam int unsigned     ID_W        = irq_id_width(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] IRQ,
  output logic [N_IRQ-1:0] IRW,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             irq_en,
  output logic             int_req,
  output logic [ID_W-1:0]  int_id,
  output logic [WIDTH-1:0] int_vec,
  input  logic             int_ack,
  input  logic             int_ret,
  output logic [N_IRQ-1:0] in_service
);

  logic [N_IRQ-1:0] sync_level;
  logic [N_IRQ-1:0] sync_rise;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] isr_q, isr_d;
  logic [N_IRQ-1:0] elig;
  logic [ID_W-1:0]  isr_top;
  logic             ack_take, ret_take;
  logic             int_req_q, int_req_d;
  logic [ID_W-1:0]  int_id_q, int_id_d;
  logic [WIDTH-1:0] int_vec_q, int_vec_d;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_chan
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i  (clk),
      .rst_ni (rst),
      .async_i(IRQ[g]),
      .level_o(sync_level[g]),
      .rise_o (sync_rise[g])
    );
  end

  // Index of the highest set bit; zero when the vector is empty.
  function automatic logic [ID_W-1:0] highest_set(logic [N_IRQ-1:0] v);
    highest_set = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (v[i]) highest_set = ID_W'(i);
    end
  endfunction

  // Channels strictly above the highest in-service one (all when idle).
  function automatic logic [N_IRQ-1:0] above_mask(logic [N_IRQ-1:0] isr);
    logic [ID_W-1:0] top;
    top        = highest_set(isr);
    above_mask = '1;
    if (|isr) begin
      for (int unsigned i = 0; i < N_IRQ; i++) begin
        above_mask[i] = (ID_W'(i) > top);
      end
    end
  endfunction

  // Next pending and in-service state; a return is applied before an ack.
  always_comb begin
    ack_take = int_ack & int_req_q;
    ret_take = int_ret & (|isr_q);
    isr_top  = highest_set(isr_q);
    isr_d    = isr_q;
    pend_d   = pend_q;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (ret_take && (ID_W'(i) == isr_top)) isr_d[i] = 1'b0;
      if (ack_take && (ID_W'(i) == int_id_q)) isr_d[i] = 1'b1;
      case (EDGE_MASK[i])
        // A fresh edge in the ack cycle wins over the clear.
        IRQ_MODE_EDGE:  pend_d[i] = (pend_q[i] & ~(ack_take && (ID_W'(i) == int_id_q)))
                                    | sync_rise[i];
        IRQ_MODE_LEVEL: pend_d[i] = sync_level[i];
        default:        pend_d[i] = pend_q[i];
      endcase
    end
  end

  // Request selection: current pending set against the post-handshake
  // in-service set, so an ack or return takes effect on the next request.
  always_comb begin
    elig      = pend_q & ~irq_mask & ~isr_d & above_mask(isr_d);
    int_req_d = irq_en & (|elig);
    int_id_d  = (|elig) ? highest_set(elig) : int_id_q;
    int_vec_d = VEC_BASE + WIDTH'(int_id_d) * VEC_STRIDE;
  end

  // State and registered CPU-facing outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q    <= '0;
      isr_q     <= '0;
      int_req_q <= 1'b0;
      int_id_q  <= '0;
      int_vec_q <= VEC_BASE;
    end else begin
      pend_q    <= pend_d;
      isr_q     <= isr_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
      int_vec_q <= int_vec_d;
    end
  end

  assign IRW        = pend_q;
  assign in_service = isr_q;
  assign int_req    = int_req_q;
  assign int_id     = int_id_q;
  assign int_vec    = int_vec_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: a cycle table for the nominal flow, hand
// sequences for level mode and asynchronous reset, then random traffic
// compared against a stack-based reference model on two mode configurations.
module tb_irq_controller;

  localparam int S = 2;
  localparam logic [2:0] EM_A = 3'b111;
  localparam logic [2:0] EM_B = 3'b110;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] IRQ = '0;
  logic [2:0] irq_mask = '0;
  logic irq_en = 1'b1;
  logic int_ack = 1'b0;
  logic int_ret = 1'b0;

  logic [2:0] irw_a, isr_a, irw_b, isr_b;
  logic req_a, req_b;
  logic [1:0] id_a, id_b;
  logic [31:0] vec_a, vec_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_controller #(.N_IRQ(3), .WIDTH(32), .SYNC_STAGES(S), .EDGE_MASK(EM_A)) dut_a (
    .clk(clk), .rst(rst), .IRQ(IRQ), .IRW(irw_a), .irq_mask(irq_mask), .irq_en(irq_en),
    .int_req(req_a), .int_id(id_a), .int_vec(vec_a), .int_ack(int_ack), .int_ret(int_ret),
    .in_service(isr_a)
  );

  irq_controller #(.N_IRQ(3), .WIDTH(32), .SYNC_STAGES(S), .EDGE_MASK(EM_B)) dut_b (
    .clk(clk), .rst(rst), .IRQ(IRQ), .IRW(irw_b), .irq_mask(irq_mask), .irq_en(irq_en),
    .int_req(req_b), .int_id(id_b), .int_vec(vec_b), .int_ack(int_ack), .int_ret(int_ret),
    .in_service(isr_b)
  );

  // Reference model: input history, pending flags, and the in-service set
  // kept as a stack of channel numbers (nesting means the top is highest).
  logic [2:0] hist [0:S+1];
  logic [2:0] m_pend [2];
  int m_stk [2][4];
  int m_sp [2];
  bit m_req [2];
  int m_id [2];

  typedef struct {
    logic [2:0] irq, mask;
    logic en, ack, ret;
    logic [2:0] irw, isr;
    logic req;
    logic [1:0] id;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] irq, input logic [2:0] mask, input logic en,
                     input logic ack, input logic ret, input logic [2:0] irw,
                     input logic [2:0] isr, input logic req, input logic [1:0] id);
    vec_t v;
    v.irq = irq; v.mask = mask; v.en = en; v.ack = ack; v.ret = ret;
    v.irw = irw; v.isr = isr; v.req = req; v.id = id;
    tbl.push_back(v);
  endtask

  function automatic logic [2:0] stack_bits(input int k);
    logic [2:0] b;
    b = '0;
    for (int j = 0; j < m_sp[k]; j++) b[m_stk[k][j]] = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    for (int j = 0; j <= S + 1; j++) hist[j] = '0;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = '0; m_sp[k] = 0; m_req[k] = 1'b0; m_id[k] = 0;
    end
  endtask

  // One rising clock edge of the reference behaviour.
  task automatic model_step();
    logic [2:0] em, old_pend, elig, rise;
    int top;
    bit take;
    for (int j = S + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = IRQ;
    rise = hist[S] & ~hist[S+1];
    for (int k = 0; k < 2; k++) begin
      em = (k == 0) ? EM_A : EM_B;
      old_pend = m_pend[k];
      take = int_ack && m_req[k];
      if (int_ret && m_sp[k] > 0) m_sp[k]--;
      if (take) begin
        m_stk[k][m_sp[k]] = m_id[k];
        m_sp[k]++;
      end
      for (int i = 0; i < 3; i++)
        m_pend[k][i] = em[i] ? ((old_pend[i] && !(take && m_id[k] == i)) || rise[i])
                             : hist[S][i];
      top = (m_sp[k] > 0) ? m_stk[k][m_sp[k]-1] : -1;
      elig = '0;
      for (int i = 0; i < 3; i++)
        if (old_pend[i] && !irq_mask[i] && i > top) elig[i] = 1'b1;
      m_req[k] = irq_en && (elig != 0);
      for (int i = 0; i < 3; i++) if (elig[i]) m_id[k] = i;
    end
  endtask

  // Advance one cycle; inputs change only at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " irw_a"}, 32'(irw_a), 32'h0);
    chk({tag, " isr_a"}, 32'(isr_a), 32'h0);
    chk({tag, " req_a"}, 32'(req_a), 32'h0);
    chk({tag, " id_a"}, 32'(id_a), 32'h0);
    chk({tag, " vec_a"}, vec_a, 32'h400);
    chk({tag, " irw_b"}, 32'(irw_b), 32'h0);
    chk({tag, " isr_b"}, 32'(isr_b), 32'h0);
    chk({tag, " req_b"}, 32'(req_b), 32'h0);
    chk({tag, " vec_b"}, vec_b, 32'h400);
  endtask

  task automatic cmp_model(input int k, input logic [2:0] irw, input logic [2:0] isr,
                           input logic req, input logic [1:0] id, input logic [31:0] vec);
    chk($sformatf("rand%0d irw", k), 32'(irw), 32'(m_pend[k]));
    chk($sformatf("rand%0d isr", k), 32'(isr), 32'(stack_bits(k)));
    chk($sformatf("rand%0d req", k), 32'(req), 32'(m_req[k]));
    if (m_req[k]) begin
      chk($sformatf("rand%0d id", k), 32'(id), 32'(m_id[k]));
      chk($sformatf("rand%0d vec", k), vec, 32'h400 + 32'(m_id[k]) * 32'h10);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // irq, mask, en, ack, ret | irw, isr, req, id  (dut_a, all edge mode)
    add(3'b010, 3'b000, 1, 0, 0, 3'b000, 3'b000, 0, 0);  // pulse ch1
    add(3'b000, 3'b000, 1, 0, 0, 3'b000, 3'b000, 0, 0);
    add(3'b000, 3'b000, 1, 0, 0, 3'b010, 3'b000, 0, 0);  // IRW after 3
    add(3'b000, 3'b000, 1, 0, 0, 3'b010, 3'b000, 1, 1);  // req after 4
    add(3'b000, 3'b000, 1, 1, 0, 3'b000, 3'b010, 0, 0);  // ack ch1
    add(3'b001, 3'b000, 1, 0, 0, 3'b000, 3'b010, 0, 0);  // pulse ch0
    add(3'b000, 3'b000, 1, 0, 0, 3'b000, 3'b010, 0, 0);
    add(3'b000, 3'b000, 1, 0, 0, 3'b001, 3'b010, 0, 0);
    add(3'b000, 3'b000, 1, 0, 0, 3'b001, 3'b010, 0, 0);  // lower: blocked
    add(3'b100, 3'b000, 1, 0, 0, 3'b001, 3'b010, 0, 0);  // pulse ch2
    add(3'b000, 3'b000, 1, 0, 0, 3'b001, 3'b010, 0, 0);
    add(3'b000, 3'b000, 1, 0, 0, 3'b101, 3'b010, 0, 0);
    add(3'b000, 3'b000, 1, 0, 0, 3'b101, 3'b010, 1, 2);  // nested request
    add(3'b000, 3'b000, 1, 1, 0, 3'b001, 3'b110, 0, 0);
    add(3'b000, 3'b000, 1, 0, 1, 3'b001, 3'b010, 0, 0);  // return ch2
    add(3'b000, 3'b000, 1, 0, 1, 3'b001, 3'b000, 1, 0);  // return ch1, ch0 asks
    add(3'b000, 3'b000, 1, 1, 0, 3'b000, 3'b001, 0, 0);
    add(3'b000, 3'b000, 1, 0, 1, 3'b000, 3'b000, 0, 0);
    add(3'b100, 3'b100, 1, 0, 0, 3'b000, 3'b000, 0, 0);  // masked ch2
    add(3'b000, 3'b100, 1, 0, 0, 3'b000, 3'b000, 0, 0);
    add(3'b000, 3'b100, 1, 0, 0, 3'b100, 3'b000, 0, 0);
    add(3'b000, 3'b100, 1, 0, 0, 3'b100, 3'b000, 0, 0);
    add(3'b000, 3'b000, 1, 0, 0, 3'b100, 3'b000, 1, 2);  // unmask
    add(3'b000, 3'b000, 0, 0, 0, 3'b100, 3'b000, 0, 0);  // global disable
    add(3'b000, 3'b000, 1, 0, 0, 3'b100, 3'b000, 1, 2);
    add(3'b000, 3'b000, 1, 1, 0, 3'b000, 3'b100, 0, 0);
    add(3'b000, 3'b000, 1, 0, 1, 3'b000, 3'b000, 0, 0);
    add(3'b010, 3'b000, 1, 0, 0, 3'b000, 3'b000, 0, 0);  // ch1 again
    add(3'b000, 3'b000, 1, 0, 0, 3'b000, 3'b000, 0, 0);
    add(3'b000, 3'b000, 1, 0, 0, 3'b010, 3'b000, 0, 0);
    add(3'b010, 3'b000, 1, 0, 0, 3'b010, 3'b000, 1, 1);  // second ch1 edge
    add(3'b000, 3'b000, 1, 0, 0, 3'b010, 3'b000, 1, 1);
    add(3'b000, 3'b000, 1, 1, 0, 3'b010, 3'b010, 0, 0);  // edge wins over ack
    add(3'b000, 3'b000, 1, 0, 1, 3'b010, 3'b000, 1, 1);
    add(3'b000, 3'b000, 1, 1, 0, 3'b000, 3'b010, 0, 0);
    add(3'b100, 3'b000, 1, 0, 0, 3'b000, 3'b010, 0, 0);
    add(3'b000, 3'b000, 1, 0, 0, 3'b000, 3'b010, 0, 0);
    add(3'b000, 3'b000, 1, 0, 0, 3'b100, 3'b010, 0, 0);
    add(3'b000, 3'b000, 1, 0, 0, 3'b100, 3'b010, 1, 2);
    add(3'b000, 3'b000, 1, 1, 1, 3'b000, 3'b100, 0, 0);  // ret then ack
    add(3'b000, 3'b000, 1, 0, 1, 3'b000, 3'b000, 0, 0);
    add(3'b000, 3'b000, 1, 0, 1, 3'b000, 3'b000, 0, 0);  // ret when idle
    add(3'b000, 3'b000, 1, 1, 0, 3'b000, 3'b000, 0, 0);  // ack when no req

    @(negedge clk);
    tick(); tick();
    chk_reset("por");
    rst = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      IRQ = tbl[r].irq; irq_mask = tbl[r].mask; irq_en = tbl[r].en;
      int_ack = tbl[r].ack; int_ret = tbl[r].ret;
      tick();
      chk($sformatf("row%0d irw", r), 32'(irw_a), 32'(tbl[r].irw));
      chk($sformatf("row%0d isr", r), 32'(isr_a), 32'(tbl[r].isr));
      chk($sformatf("row%0d req", r), 32'(req_a), 32'(tbl[r].req));
      if (tbl[r].req) begin
        chk($sformatf("row%0d id", r), 32'(id_a), 32'(tbl[r].id));
        chk($sformatf("row%0d vec", r), vec_a, 32'h400 + 32'(tbl[r].id) * 32'h10);
      end
    end
    IRQ = '0; irq_mask = '0; irq_en = 1'b1; int_ack = 1'b0; int_ret = 1'b0;

    // Level-mode channel 0 on dut_b.
    rst = 1'b0; tick(); tick(); rst = 1'b1;
    IRQ = 3'b001;
    tick(); tick(); tick();
    chk("lvl irw", 32'(irw_b), 32'h1);
    chk("lvl req early", 32'(req_b), 32'h0);
    tick();
    chk("lvl req", 32'(req_b), 32'h1);
    chk("lvl id", 32'(id_b), 32'h0);
    chk("lvl vec", vec_b, 32'h400);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("lvl ack isr", 32'(isr_b), 32'h1);
    chk("lvl ack pend", 32'(irw_b), 32'h1);
    chk("lvl ack req", 32'(req_b), 32'h0);
    tick();
    chk("lvl hold req", 32'(req_b), 32'h0);
    int_ret = 1'b1; tick(); int_ret = 1'b0;
    chk("lvl ret isr", 32'(isr_b), 32'h0);
    chk("lvl rereq", 32'(req_b), 32'h1);
    IRQ = 3'b000;
    tick(); tick();
    chk("lvl release early", 32'(irw_b), 32'h1);
    tick();
    chk("lvl release", 32'(irw_b), 32'h0);
    tick();
    chk("lvl req drop", 32'(req_b), 32'h0);

    // Asynchronous reset while channels 0 and 2 are in service on dut_a.
    rst = 1'b0; tick(); tick(); rst = 1'b1;
    IRQ = 3'b001; tick(); IRQ = 3'b000;
    for (int n = 0; n < 10 && !req_a; n++) tick();
    chk("mh req ch0", 32'(req_a), 32'h1);
    chk("mh id ch0", 32'(id_a), 32'h0);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    IRQ = 3'b100; tick(); IRQ = 3'b000;
    for (int n = 0; n < 10 && !req_a; n++) tick();
    chk("mh req ch2", 32'(req_a), 32'h1);
    chk("mh id ch2", 32'(id_a), 32'h2);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("mh isr", 32'(isr_a), 32'h5);
    #2 rst = 1'b0;
    #1 chk_reset("mid");
    model_reset();
    tick();
    rst = 1'b1;

    // Random traffic against the reference model on both configurations.
    for (int c = 0; c < 3000; c++) begin
      IRQ = IRQ ^ 3'($urandom & $urandom);
      irq_mask = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      irq_en = ($urandom_range(0, 15) != 0);
      int_ack = ($urandom_range(0, 2) == 0);
      int_ret = ($urandom_range(0, 5) == 0);
      tick();
      cmp_model(0, irw_a, isr_a, req_a, id_a, vec_a);
      cmp_model(1, irw_b, isr_b, req_b, id_b, vec_b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
